// File: rtl/mx_blk_norm_if.sv
// Handshake and data bundle for the MX block-normalisation stage.
// Latency: none (wiring only).
// Backpressure: carries i_valid/o_ready on the input side and o_valid/i_ready on the output side.
//
// Signals:
//   i_valid, i_num            : input element and its valid
//   o_ready                   : stage can take an input element
//   o_valid, i_ready          : output element valid / downstream accepts
//   o_sign, o_mag             : sign and magnitude of the current output element
//   o_shift, o_scale, o_last  : block shift, block shared scale, last-of-block flag
// Modports: slave = the normalisation stage, master = the surrounding logic.
interface mx_blk_norm_if #(
  parameter int width_i     = 8,
  parameter int width_shift = 8
);
  localparam int SW = $clog2(width_i) + 1;

  logic                   i_valid;
  logic                   o_ready;
  logic [width_i-1:0]     i_num;
  logic                   o_valid;
  logic                   i_ready;
  logic                   o_sign;
  logic [width_i-1:0]     o_mag;
  logic [width_shift-1:0] o_shift;
  logic [SW-1:0]          o_scale;
  logic                   o_last;

  modport slave (
    input  i_valid, i_num, i_ready,
    output o_ready, o_valid, o_sign, o_mag, o_shift, o_scale, o_last
  );

  modport master (
    output i_valid, i_num, i_ready,
    input  o_ready, o_valid, o_sign, o_mag, o_shift, o_scale, o_last
  );
endinterface

// File: rtl/mx_blk_norm.sv
// Collects one MX block of signed values, finds the block-max magnitude, then replays sign/magnitude with block shift/scale.
// Latency: first output element is valid the cycle after the last input of the block is accepted.
// Backpressure: input accepted only while filling; while draining, outputs hold stable when i_ready is low.
//
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous reset, active-high
//   bus   : mx_blk_norm_if.slave (input element handshake, output element handshake and block metadata)
module mx_blk_norm #(
  parameter int width_i     = 8,
  parameter int BLOCK_SIZE  = 32,
  parameter int width_shift = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mx_blk_norm_if.slave bus
);

  localparam int CW  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int LZW = $clog2(width_i) + 1;  // holds 0..width_i
  localparam logic [CW-1:0]  LAST_IDX = CW'(BLOCK_SIZE - 1);
  localparam logic [LZW-1:0] LZ_EMPTY = LZW'(width_i);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [CW-1:0]      idx;
  logic [LZW-1:0]     min_lz;

  logic               sign_buf [BLOCK_SIZE];
  logic [width_i-1:0] mag_buf  [BLOCK_SIZE];

  logic               in_sign;
  logic [width_i-1:0] in_mag;
  logic [LZW-1:0]     in_lz;
  logic [LZW-1:0]     blk_lz;
  logic               all_zero;
  logic [width_shift-1:0] nxt_shift;
  logic [LZW-1:0]     nxt_scale;
  logic               accept;
  logic               advance;
  logic [CW-1:0]      idx_nxt;

  // Leading-zero count; an all-zero value reports width_i.
  function automatic logic [LZW-1:0] clz(input logic [width_i-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = LZ_EMPTY;
    found = 1'b0;
    for (int b = width_i - 1; b >= 0; b--) begin
      if (!found && v[b]) begin
        n     = LZW'(width_i - 1 - b);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  always_comb begin
    in_sign = bus.i_num[width_i-1];
    // Two's-complement negate; the most-negative input wraps to 2^(width_i-1),
    // which is exactly its magnitude as an unsigned width_i value.
    in_mag  = in_sign ? ((~bus.i_num) + width_i'(1)) : bus.i_num;
    in_lz   = clz(in_mag);
    // Min-lz including the element being accepted this cycle, so the last
    // element of the block contributes to the registered shift/scale.
    blk_lz  = (in_lz < min_lz) ? in_lz : min_lz;
    all_zero  = (blk_lz == LZ_EMPTY);
    nxt_shift = all_zero ? '0 : width_shift'(blk_lz);
    nxt_scale = all_zero ? '0 : (LZW'(width_i - 1) - blk_lz);
    accept  = bus.o_ready && bus.i_valid;
    advance = bus.o_valid && bus.i_ready;
    idx_nxt = idx + CW'(1);
  end

  // Block buffer: contents are don't-care after reset, so no reset here.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      sign_buf[count] <= in_sign;
      mag_buf[count]  <= in_mag;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= FILL;
      count       <= '0;
      idx         <= '0;
      min_lz      <= LZ_EMPTY;
      bus.o_ready <= 1'b1;
      bus.o_valid <= 1'b0;
      bus.o_sign  <= 1'b0;
      bus.o_mag   <= '0;
      bus.o_shift <= '0;
      bus.o_scale <= '0;
      bus.o_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            min_lz <= blk_lz;
            if (count == LAST_IDX) begin
              state       <= DRAIN;
              bus.o_ready <= 1'b0;
              bus.o_valid <= 1'b1;
              bus.o_shift <= nxt_shift;
              bus.o_scale <= nxt_scale;
              // Element 0 was written in an earlier cycle (block holds >= 2),
              // so it can be presented straight from the buffer.
              bus.o_sign  <= sign_buf[0];
              bus.o_mag   <= mag_buf[0];
              bus.o_last  <= 1'b0;
              idx         <= '0;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (advance) begin
            if (bus.o_last) begin
              state       <= FILL;
              count       <= '0;
              idx         <= '0;
              min_lz      <= LZ_EMPTY;
              bus.o_ready <= 1'b1;
              bus.o_valid <= 1'b0;
              bus.o_sign  <= 1'b0;
              bus.o_mag   <= '0;
              bus.o_shift <= '0;
              bus.o_scale <= '0;
              bus.o_last  <= 1'b0;
            end else begin
              idx        <= idx_nxt;
              bus.o_sign <= sign_buf[idx_nxt];
              bus.o_mag  <= mag_buf[idx_nxt];
              bus.o_last <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mx_blk_norm.sv
// Self-checking bench for mx_blk_norm with BLOCK_SIZE=4, width_i=8.
// Latency: checks first output the cycle after the 4th accept.
// Backpressure: exercises i_ready stalls and i_valid gaps, including randomized blocks.
module tb_mx_blk_norm;

  localparam int W  = 8;
  localparam int BS = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mx_blk_norm_if #(.width_i(W), .width_shift(8)) bus ();

  mx_blk_norm #(.width_i(W), .BLOCK_SIZE(BS), .width_shift(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int abs_i(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int bitlen(input int m);
    int b;
    b = 0;
    while (m > 0) begin
      b++;
      m = m / 2;
    end
    return b;
  endfunction

  function automatic int blk_max(input int v[4]);
    int mx;
    mx = 0;
    for (int i = 0; i < BS; i++) if (abs_i(v[i]) > mx) mx = abs_i(v[i]);
    return mx;
  endfunction

  function automatic int exp_shift(input int v[4]);
    return (blk_max(v) == 0) ? 0 : W - bitlen(blk_max(v));
  endfunction

  function automatic int exp_scale(input int v[4]);
    return (blk_max(v) == 0) ? 0 : bitlen(blk_max(v)) - 1;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send_block(input int v[4], input int gap_pct, output bit tmo);
    bit acc;
    int n;
    tmo = 1'b0;
    for (int i = 0; i < BS; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.i_valid = 1'b1;
      bus.i_num   = 8'(v[i]);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
        acc = bus.o_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) tmo = 1'b1;
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic collect_block(input int stall_pct,
                               output logic s[4], output logic [7:0] m[4],
                               output logic [7:0] sh[4], output logic [3:0] sc[4],
                               output logic l[4], output bit tmo, output bit rdy_bad);
    int k;
    int n;
    k = 0;
    n = 0;
    rdy_bad = 1'b0;
    for (int i = 0; i < BS; i++) begin
      s[i] = 1'bx; m[i] = 'x; sh[i] = 'x; sc[i] = 'x; l[i] = 1'bx;
    end
    while (k < BS && n < 300) begin
      bus.i_ready = ($urandom_range(99) >= stall_pct);
      if (bus.o_valid && bus.o_ready) rdy_bad = 1'b1;
      if (bus.o_valid && bus.i_ready) begin
        s[k] = bus.o_sign; m[k] = bus.o_mag; sh[k] = bus.o_shift;
        sc[k] = bus.o_scale; l[k] = bus.o_last;
        k++;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.i_ready = 1'b0;
    tmo = (k < BS);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_num = '0; bus.i_ready = 1'b0;
    #12;
    tests++;
    if ({bus.o_valid, bus.o_sign, bus.o_mag, bus.o_shift, bus.o_scale, bus.o_last} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got v=%0b s=%0b m=%0d sh=%0d sc=%0d l=%0b expected all 0",
               bus.o_valid, bus.o_sign, bus.o_mag, bus.o_shift, bus.o_scale, bus.o_last);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready got rdy=%0b v=%0b expected rdy=1 v=0", bus.o_ready, bus.o_valid);
    end
  endtask

  task automatic run_block_check(input string name, input int v[4], input int gap, input int stall);
    logic s[4]; logic [7:0] m[4]; logic [7:0] sh[4]; logic [3:0] sc[4]; logic l[4];
    bit to; bit rb;
    send_block(v, gap, to);
    tests++;
    if (to || bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s_latency got v=%0b rdy=%0b timeout=%0b expected v=1 rdy=0 after last accept",
               name, bus.o_valid, bus.o_ready, to);
    end
    collect_block(stall, s, m, sh, sc, l, to, rb);
    tests++;
    if (to || rb) begin
      fails++;
      $display("FAIL %s_drain got timeout=%0b ready_during_drain=%0b expected 0 0", name, to, rb);
    end
    for (int i = 0; i < BS; i++) begin
      tests++;
      if ({s[i], m[i], sh[i], sc[i], l[i]} !==
          {1'(v[i] < 0), 8'(abs_i(v[i])), 8'(exp_shift(v)), 4'(exp_scale(v)), 1'(i == BS - 1)}) begin
        fails++;
        $display("FAIL %s_elem%0d got s=%0b m=%0d sh=%0d sc=%0d l=%0b expected s=%0b m=%0d sh=%0d sc=%0d l=%0b",
                 name, i, s[i], m[i], sh[i], sc[i], l[i], v[i] < 0, abs_i(v[i]),
                 exp_shift(v), exp_scale(v), i == BS - 1);
      end
    end
    tests++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_refill got rdy=%0b v=%0b expected rdy=1 v=0", name, bus.o_ready, bus.o_valid);
    end
  endtask

  task automatic test_basic();
    int v[4];
    v = '{3, -12, 0, 5};
    run_block_check("basic", v, 0, 0);
  endtask

  task automatic test_all_zero();
    int v[4];
    v = '{0, 0, 0, 0};
    run_block_check("zero", v, 0, 0);
  endtask

  task automatic test_most_negative();
    int v[4];
    v = '{-128, 1, 1, 1};
    run_block_check("mostneg", v, 0, 0);
  endtask

  task automatic test_backpressure();
    int v[4];
    bit to;
    int exp_m;
    v = '{7, 1, 2, 3};
    send_block(v, 0, to);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;          // element 0 taken
    bus.i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tests++;
      if (bus.o_valid !== 1'b1 || bus.o_mag !== 8'd1 || bus.o_ready !== 1'b0 || bus.o_last !== 1'b0) begin
        fails++;
        $display("FAIL stall_cyc%0d got v=%0b m=%0d rdy=%0b l=%0b expected v=1 m=1 rdy=0 l=0",
                 c, bus.o_valid, bus.o_mag, bus.o_ready, bus.o_last);
      end
    end
    bus.i_ready = 1'b1;
    for (int i = 1; i < BS; i++) begin
      exp_m = v[i];
      tests++;
      if ({bus.o_valid, bus.o_mag, bus.o_shift, bus.o_scale, bus.o_last} !==
          {1'b1, 8'(exp_m), 8'(exp_shift(v)), 4'(exp_scale(v)), 1'(i == BS - 1)}) begin
        fails++;
        $display("FAIL stall_release%0d got v=%0b m=%0d sh=%0d sc=%0d l=%0b expected v=1 m=%0d sh=%0d sc=%0d l=%0b",
                 i, bus.o_valid, bus.o_mag, bus.o_shift, bus.o_scale, bus.o_last,
                 exp_m, exp_shift(v), exp_scale(v), i == BS - 1);
      end
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b0;
    tests++;
    if (to || bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_end got rdy=%0b timeout=%0b expected rdy=1 timeout=0", bus.o_ready, to);
    end
  endtask

  task automatic test_back_to_back();
    int v[4];
    v = '{64, 1, 1, 1};
    run_block_check("b2b_1", v, 0, 0);
    v = '{1, 2, 1, 1};
    run_block_check("b2b_2", v, 0, 0);
  endtask

  task automatic test_async_reset();
    int v[4];
    bit to;
    v = '{5, -6, 7, 8};
    send_block(v, 0, to);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;          // two outputs consumed
    bus.i_ready = 1'b0;
    tests++;
    if (to || bus.o_valid !== 1'b1 || bus.o_mag !== 8'd7) begin
      fails++;
      $display("FAIL areset_pre got v=%0b m=%0d timeout=%0b expected v=1 m=7", bus.o_valid, bus.o_mag, to);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_mag !== 8'd0 || bus.o_shift !== 8'd0) begin
      fails++;
      $display("FAIL areset_async got v=%0b m=%0d sh=%0d expected 0 0 0", bus.o_valid, bus.o_mag, bus.o_shift);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL areset_ready got rdy=%0b expected 1", bus.o_ready);
    end
    v = '{2, 2, 2, 2};
    run_block_check("areset_clean", v, 0, 0);
  endtask

  task automatic test_random();
    int v[4];
    logic [7:0] r;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < BS; i++) begin
        r    = 8'($urandom_range(255));
        v[i] = int'($signed(r)) >>> $urandom_range(7);
      end
      run_block_check($sformatf("rand%0d", b), v, 30, 30);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_all_zero();
    test_most_negative();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
